// File: rtl/obstacle_spawner_if.sv
// obstacle_spawner_if: game-clock inputs and playfield outputs of the obstacle spawner
interface obstacle_spawner_if #(
  parameter int NSLOT = 4,
  parameter int X_W = 10
);
  logic game_clk;
  logic [8:0] min_empty;
  logic run;
  logic tick;
  logic [NSLOT-1:0] obs_valid;
  logic [NSLOT*X_W-1:0] obs_x;
  logic [NSLOT*2-1:0] obs_type;
  logic [15:0] pass_cnt;
  modport master (output game_clk, min_empty, run, input tick, obs_valid, obs_x, obs_type, pass_cnt);
  modport slave (input game_clk, min_empty, run, output tick, obs_valid, obs_x, obs_type, pass_cnt);
endinterface

// File: rtl/obstacle_spawner.sv
// obstacle_spawner: scrolls obstacles left on each game-clock step and spawns new ones via an LFSR
module obstacle_spawner #(
  parameter int SCREEN_W = 640,
  parameter int NSLOT = 4,
  parameter int X_W = 10,
  parameter int STEP = 1,
  parameter int SPAWN_THR = 8,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input logic clk,
  input logic rst,
  obstacle_spawner_if.slave bus
);
  logic s1, s2, s3, step, tick, spawn, ok;
  logic [15:0] lfsr, pass_cnt, pass_n;
  logic [16:0] sum;
  logic [8:0] gap_cnt, gap_next, gap_n;
  logic [NSLOT-1:0] valid, valid_n;
  logic [X_W-1:0] x [NSLOT];
  logic [X_W-1:0] x_n [NSLOT];
  logic [1:0] typ [NSLOT];
  logic [1:0] typ_n [NSLOT];
  assign step = s2 & ~s3;
  assign gap_next = (gap_cnt == 9'h1FF) ? gap_cnt : gap_cnt + 9'd1;
  assign ok = (gap_next >= bus.min_empty) && ({1'b0, lfsr[3:0]} < 5'(SPAWN_THR));
  // Spawn targets only slots free before the step, so a retiring slot waits a step
  always_comb begin
    valid_n = valid;
    x_n = x;
    typ_n = typ;
    spawn = 1'b0;
    sum = {1'b0, pass_cnt};
    for (int i = 0; i < NSLOT; i++) begin
      if (valid[i] && x[i] == '0) begin
        valid_n[i] = 1'b0;
        sum = sum + 17'd1;
      end else x_n[i] = (x[i] < X_W'(STEP)) ? '0 : x[i] - X_W'(STEP);
      if (!valid[i] && !spawn && ok) begin
        spawn = 1'b1;
        valid_n[i] = 1'b1;
        x_n[i] = X_W'(SCREEN_W - 1);
        typ_n[i] = lfsr[5:4];
      end
    end
    pass_n = sum[16] ? 16'hFFFF : sum[15:0];
    gap_n = spawn ? 9'd0 : gap_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= bus.game_clk;
      s2 <= bus.game_clk;
      s3 <= bus.game_clk;
      tick <= 1'b0;
      lfsr <= SEED;
      gap_cnt <= '0;
      pass_cnt <= '0;
      valid <= '0;
      x <= '{default: '0};
      typ <= '{default: '0};
    end else begin
      s1 <= bus.game_clk;
      s2 <= s1;
      s3 <= s2;
      tick <= step;
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      if (step && bus.run) begin
        gap_cnt <= gap_n;
        pass_cnt <= pass_n;
        valid <= valid_n;
        x <= x_n;
        typ <= typ_n;
      end
    end
  end
  assign bus.tick = tick;
  assign bus.obs_valid = valid;
  assign bus.pass_cnt = pass_cnt;
  for (genvar g = 0; g < NSLOT; g++) begin : g_out
    assign bus.obs_x[g*X_W +: X_W] = x[g];
    assign bus.obs_type[g*2 +: 2] = typ[g];
  end
endmodule

// File: tb/tb_obstacle_spawner.sv
// tb_obstacle_spawner: scoreboard bench; stimulus pushes expected playfield per step, monitor checks on tick
module tb_obstacle_spawner;
  typedef struct packed {
    logic [3:0] v;
    logic [39:0] x;
    logic [2:0] sp;
    logic [15:0] pass;
  } exp_t;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0, ticks = 0;
  exp_t q[$];
  bit mv[4];
  int mx[4], mpass, mgap;
  logic [15:0] lf, lf_prev;
  logic [1:0] exp_type[4];
  obstacle_spawner_if #(.NSLOT(4), .X_W(10)) bus();
  obstacle_spawner #(.SPAWN_THR(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    lf_prev <= lf;
    lf <= rst ? 16'hACE1 : {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask
  function automatic int sx(input int i);
    return int'(bus.obs_x[i*10 +: 10]);
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin mv[i] = 0; mx[i] = 0; end
    mpass = 0;
    mgap = 0;
  endtask
  task automatic model_step();
    exp_t e;
    int gn, sp;
    sp = 4;
    if (bus.run) begin
      gn = (mgap + 1 > 511) ? 511 : mgap + 1;
      for (int i = 0; i < 4; i++) if (!mv[i] && sp == 4 && gn >= int'(bus.min_empty)) sp = i;
      for (int i = 0; i < 4; i++)
        if (mv[i] && mx[i] == 0) begin mv[i] = 0; mpass++; end
        else mx[i] = (mx[i] < 1) ? 0 : mx[i] - 1;
      if (mpass > 65535) mpass = 65535;
      if (sp < 4) begin mv[sp] = 1; mx[sp] = 639; mgap = 0; end
      else mgap = gn;
    end
    for (int i = 0; i < 4; i++) begin
      e.v[i] = mv[i];
      e.x[i*10 +: 10] = 10'(mx[i]);
    end
    e.sp = 3'(sp);
    e.pass = 16'(mpass);
    q.push_back(e);
  endtask
  task automatic step();
    model_step();
    @(negedge clk) bus.game_clk = 1;
    repeat (2) @(negedge clk);
    bus.game_clk = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    model_reset();
    @(negedge clk);
    chk("rst_valid", int'(bus.obs_valid), 0);
    chk("rst_pass", int'(bus.pass_cnt), 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.tick) begin
        ticks++;
        if (q.size() == 0) chk("unexpected_tick", 1, 0);
        else begin
          e = q.pop_front();
          if (e.sp < 4) exp_type[e.sp] = lf_prev[5:4];
          chk("sb_valid", int'(bus.obs_valid), int'(e.v));
          chk("sb_pass", int'(bus.pass_cnt), int'(e.pass));
          for (int i = 0; i < 4; i++) if (e.v[i]) begin
            chk("sb_x", sx(i), int'(e.x[i*10 +: 10]));
            chk("sb_type", int'(bus.obs_type[i*2 +: 2]), int'(exp_type[i]));
          end
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t0;
    bus.game_clk = 0;
    bus.min_empty = 9'd10;
    bus.run = 1;
    model_reset();
    repeat (5) begin @(negedge clk); bus.game_clk = ~bus.game_clk; end
    @(negedge clk) rst = 0;
    chk("rel_tick", int'(bus.tick), 0);
    chk("rel_valid", int'(bus.obs_valid), 0);
    chk("rel_pass", int'(bus.pass_cnt), 0);
    repeat (4) begin @(negedge clk); chk("no_tick_after_rst", int'(bus.tick), 0); end
    bus.game_clk = 0;
    repeat (6) begin @(negedge clk); chk("no_tick_fall", int'(bus.tick), 0); end
    model_step();
    @(negedge clk) bus.game_clk = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("latency", int'(bus.tick), (k == 2) ? 1 : 0);
    end
    @(negedge clk) bus.game_clk = 0;
    repeat (2) @(negedge clk);
    repeat (8) step();
    chk("gap_none_by_9", int'(bus.obs_valid), 0);
    step();
    chk("gap_spawn10_valid", int'(bus.obs_valid), 1);
    chk("gap_spawn10_x0", sx(0), 639);
    repeat (9) step();
    chk("gap_none_by_19", int'(bus.obs_valid), 1);
    step();
    chk("gap_spawn20_valid", int'(bus.obs_valid), 3);
    chk("gap_spawn20_x0", sx(0), 629);
    chk("gap_spawn20_x1", sx(1), 639);
    do_reset();
    bus.min_empty = 9'd0;
    step();
    bus.min_empty = 9'd511;
    repeat (639) step();
    chk("ret_x0_zero", sx(0), 0);
    chk("ret_valid_before", int'(bus.obs_valid[0]), 1);
    step();
    chk("ret_valid_after", int'(bus.obs_valid[0]), 0);
    chk("ret_pass", int'(bus.pass_cnt), 1);
    chk("ret_x1", sx(1), 510);
    do_reset();
    bus.min_empty = 9'd0;
    repeat (4) step();
    chk("full_valid4", int'(bus.obs_valid), 15);
    chk("full_x0", sx(0), 636);
    chk("full_x3", sx(3), 639);
    step();
    chk("full_step5_valid", int'(bus.obs_valid), 15);
    chk("full_step5_x0", sx(0), 635);
    bus.min_empty = 9'd511;
    repeat (636) step();
    chk("full_641_valid", int'(bus.obs_valid), 14);
    chk("full_641_pass", int'(bus.pass_cnt), 1);
    step();
    chk("full_642_valid", int'(bus.obs_valid), 13);
    chk("full_642_pass", int'(bus.pass_cnt), 2);
    chk("full_642_x0", sx(0), 639);
    bus.run = 0;
    t0 = ticks;
    repeat (100) step();
    chk("frz_ticks", ticks - t0, 100);
    chk("frz_valid", int'(bus.obs_valid), 13);
    chk("frz_pass", int'(bus.pass_cnt), 2);
    chk("frz_x0", sx(0), 639);
    chk("frz_x2", sx(2), 0);
    chk("frz_x3", sx(3), 1);
    bus.run = 1;
    step();
    chk("resume_valid", int'(bus.obs_valid), 9);
    chk("resume_pass", int'(bus.pass_cnt), 3);
    chk("resume_x0", sx(0), 638);
    chk("resume_x3", sx(3), 0);
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
